e203_exu_wbck_arb: RTL and testbench

// - N-source, multi-thread write-back arbiter with a registered output stage feeding the integer regfile write port.
// - Successor to the 2-source ALU/long-pipe write-back mux: adds parametrised source count, regfile back-pressure,
//   a starvation guard on fixed priority, and optional round-robin arbitration.
// - Sits between the EXU result producers (ALU, LSU, MULDIV, FPU, ...) and the regfile in e203_exu.

---
 rtl/e203_exu_wbck_arb.sv | 155 +++++++++++++++
 tb/tb_e203_exu_wbck_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_wbck_arb.sv
// e203_exu_wbck_arb: N-source write-back arbiter with a one-entry registered
// output stage feeding the integer regfile write port.
// Build option: define E203_WBCK_RR_EN to replace fixed priority (with the
// starvation guard) by round-robin arbitration.
module e203_exu_wbck_arb #(
  parameter int NSRC       = 2,
  parameter int THREADS    = 2,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 4,
  parameter int SRC_W      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC*THREADS-1:0] src_thread_sel,
  input  logic [NSRC*XLEN-1:0]    src_wdat,
  input  logic [NSRC*RFIDX_W-1:0] src_rdidx,
  input  logic [NSRC-1:0]         src_rdfpu,
  input  logic                    rf_wbck_o_ready,
  output logic                    rf_wbck_o_ena,
  output logic [THREADS-1:0]      rf_wbck_o_thread_sel,
  output logic [XLEN-1:0]         rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]      rf_wbck_o_rdidx,
  output logic [SRC_W-1:0]        rf_wbck_o_src
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic               out_vld;
  logic               out_rdfpu;
  logic [THREADS-1:0] out_thread;
  logic [XLEN-1:0]    out_wdat;
  logic [RFIDX_W-1:0] out_rdidx;
  logic [SRC_W-1:0]   out_src;

  logic               stage_free;
  logic               win_vld;
  logic [SRC_W-1:0]   win_idx;
  logic               grant_any;
  logic [NSRC-1:0]    grant;
  logic [3:0]         starve_cnt [NSRC];

  // the stage can take a new entry when empty or draining this cycle
  assign stage_free = ~out_vld | rf_wbck_o_ready;

`ifdef E203_WBCK_RR_EN
  logic [SRC_W-1:0] rr_ptr;
  int               rr_pos;

  // round-robin: first valid source at or after the pointer, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_pos  = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      rr_pos = int'(rr_ptr) + k;
      if (rr_pos >= NSRC) rr_pos = rr_pos - NSRC;
      if (src_valid[rr_pos]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(rr_pos);
      end
    end
  end

  // pointer moves just past the source that was granted
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(win_idx) == NSRC - 1) ? '0 : win_idx + 1'b1;
    end
  end
`else
  logic             st_found;
  logic [SRC_W-1:0] st_idx;
  logic             pr_found;
  logic [SRC_W-1:0] pr_idx;

  // lowest-index starved source and highest-index valid source
  always_comb begin
    st_found = 1'b0;
    st_idx   = '0;
    pr_found = 1'b0;
    pr_idx   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_valid[i] && (starve_cnt[i] == STARVE_LIM) && !st_found) begin
        st_found = 1'b1;
        st_idx   = SRC_W'(i);
      end
      if (src_valid[i]) begin
        pr_found = 1'b1;
        pr_idx   = SRC_W'(i);
      end
    end
  end

  assign win_vld = pr_found;
  assign win_idx = st_found ? st_idx : pr_idx;
`endif

  // one-hot grant, only when the output stage can accept
  always_comb begin
    grant = '0;
    if (stage_free && win_vld) grant[win_idx] = 1'b1;
  end

  assign grant_any = stage_free & win_vld;
  assign src_ready = grant;

  // starvation counters: count lost cycles, hold while the stage is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) starve_cnt[i] <= '0;
    end else if (stage_free) begin
      for (int i = 0; i < NSRC; i++) begin
        if (grant[i] || !src_valid[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != STARVE_LIM) begin
          starve_cnt[i] <= starve_cnt[i] + 4'd1;
        end
      end
    end
  end

  // output stage: a new grant reloads the entry, otherwise drain on ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_rdfpu  <= 1'b0;
      out_thread <= '0;
      out_wdat   <= '0;
      out_rdidx  <= '0;
      out_src    <= '0;
    end else if (grant_any) begin
      out_vld    <= 1'b1;
      out_rdfpu  <= src_rdfpu[win_idx];
      out_thread <= src_thread_sel[int'(win_idx)*THREADS +: THREADS];
      out_wdat   <= src_wdat[int'(win_idx)*XLEN +: XLEN];
      out_rdidx  <= src_rdidx[int'(win_idx)*RFIDX_W +: RFIDX_W];
      out_src    <= win_idx;
    end else if (rf_wbck_o_ready) begin
      out_vld    <= 1'b0;
    end
  end

  // FP-destination entries drain through the stage without a write strobe
  assign rf_wbck_o_ena        = out_vld & rf_wbck_o_ready & ~out_rdfpu;
  assign rf_wbck_o_thread_sel = out_vld ? out_thread : '0;
  assign rf_wbck_o_wdat       = out_wdat;
  assign rf_wbck_o_rdidx      = out_rdidx;
  assign rf_wbck_o_src        = out_src;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
module tb_e203_exu_wbck_arb;
  localparam int NSRC       = 3;
  localparam int THREADS    = 2;
  localparam int XLEN       = 32;
  localparam int RFIDX_W    = 5;
  localparam int STARVE_MAX = 4;
  localparam int SRC_W      = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NSRC-1:0]         src_valid;
  logic [NSRC-1:0]         src_ready;
  logic [NSRC*THREADS-1:0] src_thread_sel;
  logic [NSRC*XLEN-1:0]    src_wdat;
  logic [NSRC*RFIDX_W-1:0] src_rdidx;
  logic [NSRC-1:0]         src_rdfpu;
  logic                    rf_ready;
  logic                    rf_ena;
  logic [THREADS-1:0]      rf_thread;
  logic [XLEN-1:0]         rf_wdat;
  logic [RFIDX_W-1:0]      rf_rdidx;
  logic [SRC_W-1:0]        rf_src;

  e203_exu_wbck_arb #(
    .NSRC(NSRC), .THREADS(THREADS), .XLEN(XLEN), .RFIDX_W(RFIDX_W),
    .STARVE_MAX(STARVE_MAX), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_thread_sel(src_thread_sel), .src_wdat(src_wdat),
    .src_rdidx(src_rdidx), .src_rdfpu(src_rdfpu),
    .rf_wbck_o_ready(rf_ready), .rf_wbck_o_ena(rf_ena),
    .rf_wbck_o_thread_sel(rf_thread), .rf_wbck_o_wdat(rf_wdat),
    .rf_wbck_o_rdidx(rf_rdidx), .rf_wbck_o_src(rf_src)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: waiting-time per source, the output entry, RR pointer
  int                 m_cnt [NSRC];
  bit                 m_vld;
  bit                 m_fpu;
  logic [THREADS-1:0] m_thr;
  logic [XLEN-1:0]    m_wdat;
  logic [RFIDX_W-1:0] m_idx;
  int                 m_src;
  int                 m_ptr;
  int                 last_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_winner();
`ifdef E203_WBCK_RR_EN
    for (int k = 0; k < NSRC; k++) begin
      int j;
      j = (m_ptr + k) % NSRC;
      if (src_valid[j]) return j;
    end
    return -1;
`else
    for (int i = 0; i < NSRC; i++)
      if (src_valid[i] && m_cnt[i] >= STARVE_MAX) return i;
    for (int i = NSRC - 1; i >= 0; i--)
      if (src_valid[i]) return i;
    return -1;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
    m_vld = 0; m_fpu = 0; m_thr = '0; m_wdat = '0; m_idx = '0; m_src = 0; m_ptr = 0;
  endtask

  task automatic check_cycle();
    int w;
    bit sf;
    logic [NSRC-1:0] er;
    #1;
    sf = !m_vld || rf_ready;
    w  = m_winner();
    er = '0;
    if (sf && w >= 0) er[w] = 1'b1;
    chk("src_ready", src_ready, er);
    chk("ena", rf_ena, m_vld && rf_ready && !m_fpu);
    chk("thread_sel", rf_thread, m_vld ? m_thr : '0);
    if (m_vld) begin
      chk("wdat", rf_wdat, m_wdat);
      chk("rdidx", rf_rdidx, m_idx);
      chk("src", rf_src, m_src);
    end
  endtask

  task automatic tick();
    int w;
    bit sf;
    sf = !m_vld || rf_ready;
    w  = m_winner();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (sf) begin
        for (int i = 0; i < NSRC; i++) begin
          if (i == w || !src_valid[i]) m_cnt[i] = 0;
          else if (m_cnt[i] < STARVE_MAX) m_cnt[i]++;
        end
      end
      if (sf && w >= 0) begin
        m_vld  = 1;
        m_fpu  = src_rdfpu[w];
        m_thr  = src_thread_sel[w*THREADS +: THREADS];
        m_wdat = src_wdat[w*XLEN +: XLEN];
        m_idx  = src_rdidx[w*RFIDX_W +: RFIDX_W];
        m_src  = w;
        m_ptr  = (w + 1) % NSRC;
      end else if (rf_ready) begin
        m_vld = 0;
      end
    end
    last_grant = (sf && w >= 0) ? w : -1;
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input bit v, input logic [THREADS-1:0] thr,
                         input logic [XLEN-1:0] d, input logic [RFIDX_W-1:0] idx, input bit fpu);
    src_valid[i]                        = v;
    src_thread_sel[i*THREADS +: THREADS] = thr;
    src_wdat[i*XLEN +: XLEN]            = d;
    src_rdidx[i*RFIDX_W +: RFIDX_W]     = idx;
    src_rdfpu[i]                        = fpu;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NSRC; i++) set_src(i, 0, '0, '0, '0, 0);
  endtask

  initial begin
    logic [NSRC-1:0] exp_seq [7];
    rst = 1'b1;
    rf_ready = 1'b1;
    last_grant = -1;
    clear_srcs();
    model_clear();
    tick();
    tick();
    check_cycle();
    chk("reset_ena", rf_ena, 1'b0);
    chk("reset_thread", rf_thread, 2'b00);
    rst = 1'b0;
    tick();

`ifdef E203_WBCK_RR_EN
    // all sources valid continuously: rotating grants, a write every cycle
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NSRC; i++) set_src(i, 1, 2'b01, 32'h1000 + c*8 + i, 5'(i + 1), 0);
      check_cycle();
      chk("rr_grant", src_ready, exp_seq[c]);
      if (c > 0) chk("rr_ena", rf_ena, 1'b1);
      tick();
    end
    clear_srcs();
    check_cycle();
    tick();
`endif

    // single write from source 0
    set_src(0, 1, 2'b10, 32'hDEADBEEF, 5'd5, 0);
    check_cycle();
    chk("single_ready", src_ready, 3'b001);
    tick();
    clear_srcs();
    check_cycle();
    chk("single_ena", rf_ena, 1'b1);
    chk("single_wdat", rf_wdat, 32'hDEADBEEF);
    chk("single_rdidx", rf_rdidx, 5'd5);
    chk("single_thread", rf_thread, 2'b10);
    chk("single_src", rf_src, 2'd0);
    tick();

`ifndef E203_WBCK_RR_EN
    // starvation: src2 valid 6 cycles, src0 valid throughout
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100, 3'b001};
    for (int c = 0; c < 7; c++) begin
      set_src(0, 1, 2'b01, 32'h100 + c, 5'd1, 0);
      set_src(2, c < 6, 2'b10, 32'h200 + c, 5'd2, 0);
      check_cycle();
      chk("starve_grant", src_ready, exp_seq[c]);
      tick();
    end
    clear_srcs();
    check_cycle();
    tick();
`endif

    // back-pressure: payload holds while the regfile port is busy
    set_src(1, 1, 2'b01, 32'hCAFE0001, 5'd7, 0);
    check_cycle();
    tick();
    set_src(1, 1, 2'b01, 32'hCAFE0002, 5'd8, 0);
    rf_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_cycle();
      chk("stall_ready", src_ready, 3'b000);
      chk("stall_ena", rf_ena, 1'b0);
      chk("stall_wdat", rf_wdat, 32'hCAFE0001);
      tick();
    end
    rf_ready = 1'b1;
    check_cycle();
    chk("unstall_ena", rf_ena, 1'b1);
    chk("unstall_ready", src_ready, 3'b010);
    tick();
    clear_srcs();
    check_cycle();
    chk("unstall_next", rf_wdat, 32'hCAFE0002);
    tick();

    // FP-destination entry occupies the stage but never writes
    set_src(2, 1, 2'b01, 32'h55, 5'd3, 1);
    check_cycle();
    tick();
    set_src(2, 1, 2'b10, 32'h66, 5'd4, 0);
    check_cycle();
    chk("fpu_ena", rf_ena, 1'b0);
    chk("fpu_thread", rf_thread, 2'b01);
    chk("fpu_ready", src_ready, 3'b100);
    tick();
    clear_srcs();
    check_cycle();
    chk("fpu_next_ena", rf_ena, 1'b1);
    tick();

    // reset while an entry is stalled in the stage
    set_src(0, 1, 2'b01, 32'h77, 5'd9, 0);
    check_cycle();
    tick();
    clear_srcs();
    rf_ready = 1'b0;
    rst = 1'b1;
    check_cycle();
    tick();
    rst = 1'b0;
    rf_ready = 1'b1;
    check_cycle();
    chk("rst_ena", rf_ena, 1'b0);
    chk("rst_thread", rf_thread, 2'b00);
    tick();

    // randomized traffic; sources keep their payload until accepted
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!src_valid[i] || last_grant == i) begin
          if ($urandom_range(0, 99) < 60)
            set_src(i, 1, THREADS'(1) << $urandom_range(0, THREADS - 1), $urandom(),
                    RFIDX_W'($urandom_range(0, 31)), $urandom_range(0, 99) < 15);
          else
            set_src(i, 0, '0, '0, '0, 0);
        end
      end
      rf_ready = $urandom_range(0, 99) < 70;
      rst      = $urandom_range(0, 99) < 2;
      check_cycle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
